fetch_buffer: RTL and testbench

Instruction prefetch stage upstream of the `riscv` core's decode path. It issues 32-bit instruction reads to `memory_bus` ahead of execution and holds fetched words with their PCs in a small FIFO. It delivers them to the core over a valid/ready handshake and discards everything on a control-flow redirect (branch, jal/jalr, reset). The core keeps ownership of the bus for load and store; an external arbiter gates this block through `bus_grant`.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_buffer.sv | 107 ++++++++++
 tb/tb_fetch_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-path constants, entry type and PC helper
package riscv_pkg;

   localparam int FETCH_PC_WIDTH = 16;
   localparam int INSTR_WIDTH    = 32;
   localparam logic [FETCH_PC_WIDTH-1:0] RESET_PC_DEFAULT = 16'h4000;

   typedef struct packed {
      logic [FETCH_PC_WIDTH-1:0] pc;
      logic [INSTR_WIDTH-1:0]    word;
   } fetch_entry_t;

   function automatic logic [FETCH_PC_WIDTH-1:0] align_pc(input logic [FETCH_PC_WIDTH-1:0] pc);
      return pc & ~FETCH_PC_WIDTH'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry FIFO of {pc, word} with clear and head outputs
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          push,
   input  fetch_entry_t  push_data,
   input  logic          pop,
   output logic [CW-1:0] count,
   output fetch_entry_t  head_data
);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of two; push into the
   // slot being popped is safe since the head is read before the edge.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction prefetch: issues bus reads, buffers words, flushes on redirect
module fetch_buffer
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter logic [FETCH_PC_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [FETCH_PC_WIDTH-1:0] flush_pc,
   input  logic                      bus_grant,
   output logic                      mem_bus_enable,
   output logic [FETCH_PC_WIDTH-1:0] mem_address,
   input  logic [INSTR_WIDTH-1:0]    mem_read,
   output logic                      instr_valid,
   output logic [INSTR_WIDTH-1:0]    instr,
   output logic [FETCH_PC_WIDTH-1:0] instr_pc,
   input  logic                      instr_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [FETCH_PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [FETCH_PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic [FETCH_PC_WIDTH-1:0] mem_address_q, mem_address_d;
   logic                      inflight_q, inflight_d;
   logic                      mem_bus_enable_q, mem_bus_enable_d;

   logic [CW-1:0]             fifo_count;
   logic [CW:0]               occupancy;
   logic [FETCH_PC_WIDTH-1:0] flush_aligned;
   logic                      pop;
   logic                      push;
   logic                      issue_ok;
   fetch_entry_t              push_entry;
   fetch_entry_t              head;

   assign instr_valid   = (fifo_count != '0);
   assign pop           = instr_valid && instr_ready;
   assign push          = inflight_q && !flush;
   assign flush_aligned = align_pc(flush_pc);

   // Slots already committed (buffered plus in flight) minus the one leaving now
   assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign issue_ok  = bus_grant && !flush && (occupancy < (CW+1)'(DEPTH));

   always_comb begin
      fetch_pc_d       = fetch_pc_q;
      inflight_pc_d    = inflight_pc_q;
      mem_address_d    = mem_address_q;
      inflight_d       = 1'b0;
      mem_bus_enable_d = 1'b0;
      if (flush) begin
         if (bus_grant) begin
            mem_bus_enable_d = 1'b1;
            mem_address_d    = flush_aligned;
            inflight_pc_d    = flush_aligned;
            inflight_d       = 1'b1;
            fetch_pc_d       = flush_aligned + FETCH_PC_WIDTH'(4);
         end else begin
            fetch_pc_d = flush_aligned;
         end
      end else if (issue_ok) begin
         mem_bus_enable_d = 1'b1;
         mem_address_d    = fetch_pc_q;
         inflight_pc_d    = fetch_pc_q;
         inflight_d       = 1'b1;
         fetch_pc_d       = fetch_pc_q + FETCH_PC_WIDTH'(4);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q       <= RESET_PC;
         inflight_pc_q    <= '0;
         mem_address_q    <= '0;
         inflight_q       <= 1'b0;
         mem_bus_enable_q <= 1'b0;
      end else begin
         fetch_pc_q       <= fetch_pc_d;
         inflight_pc_q    <= inflight_pc_d;
         mem_address_q    <= mem_address_d;
         inflight_q       <= inflight_d;
         mem_bus_enable_q <= mem_bus_enable_d;
      end
   end

   assign push_entry = '{pc: inflight_pc_q, word: mem_read};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .clear     (flush),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .count     (fifo_count),
      .head_data (head)
   );

   assign mem_bus_enable = mem_bus_enable_q;
   assign mem_address    = mem_address_q;
   assign instr          = head.word;
   assign instr_pc       = head.pc;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - self-checking bench for fetch_buffer
module tb_fetch_buffer;
   import riscv_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] flush_pc = '0;
   logic        bus_grant = 1'b0;
   logic        instr_ready = 1'b0;
   logic        mem_bus_enable;
   logic [15:0] mem_address;
   logic [31:0] mem_read;
   logic        instr_valid;
   logic [31:0] instr;
   logic [15:0] instr_pc;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {~a, a};
   endfunction

   assign mem_read = mem_word(mem_address);

   fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(16'h4000)) dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .flush_pc       (flush_pc),
      .bus_grant      (bus_grant),
      .mem_bus_enable (mem_bus_enable),
      .mem_address    (mem_address),
      .mem_read       (mem_read),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   // Reference model: queue of buffered PCs plus the single outstanding request
   logic [15:0] m_q[$];
   logic [15:0] m_fpc;
   logic        m_inf;
   logic [15:0] m_infpc;
   logic        m_en;
   logic [15:0] m_addr;

   task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_fpc   = 16'h4000;
      m_inf   = 1'b0;
      m_infpc = '0;
      m_en    = 1'b0;
      m_addr  = '0;
   endtask

   task automatic model_edge();
      logic        do_pop;
      int          committed;
      logic [15:0] al;
      do_pop = (m_q.size() != 0) && instr_ready;
      al     = flush_pc & 16'hFFFC;
      if (flush) begin
         m_q.delete();
         if (bus_grant) begin
            m_en = 1; m_addr = al; m_inf = 1; m_infpc = al; m_fpc = al + 16'd4;
         end else begin
            m_en = 0; m_inf = 0; m_fpc = al;
         end
      end else begin
         committed = m_q.size() + int'(m_inf) - int'(do_pop);
         if (do_pop) void'(m_q.pop_front());
         if (m_inf) m_q.push_back(m_infpc);
         if (bus_grant && committed < DEPTH) begin
            m_en = 1; m_addr = m_fpc; m_infpc = m_fpc; m_inf = 1; m_fpc = m_fpc + 16'd4;
         end else begin
            m_en = 0; m_inf = 0;
         end
      end
      if (m_q.size() > DEPTH) begin
         n_err++;
         $display("FAIL model_overflow: got %0d entries, limit %0d", m_q.size(), DEPTH);
      end
   endtask

   // Advance one clock and compare DUT against the model 1 ns after the edge
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("instr_valid", 48'(instr_valid), 48'(m_q.size() != 0));
      chk("mem_bus_enable", 48'(mem_bus_enable), 48'(m_en));
      chk("mem_address", 48'(mem_address), 48'(m_addr));
      if (m_q.size() != 0) begin
         chk("instr_pc", 48'(instr_pc), 48'(m_q[0]));
         chk("instr", 48'(instr), 48'(mem_word(m_q[0])));
      end
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      flush = 1'b0; bus_grant = 1'b0; instr_ready = 1'b0; flush_pc = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   typedef struct {
      logic        fl;
      logic [15:0] fpc;
      logic        gr;
      logic        rd;
      logic        ev;
      logic [15:0] epc;
      logic        een;
      logic [15:0] eaddr;
   } vec_t;

   vec_t vt[16];

   initial begin
      vt[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4000};
      vt[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h4000, 1'b1, 16'h4004};
      vt[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h4000, 1'b1, 16'h4008};
      vt[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h4000, 1'b1, 16'h400C};
      vt[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h4000, 1'b0, 16'h400C};
      vt[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h4000, 1'b0, 16'h400C};
      vt[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h4004, 1'b1, 16'h4010};
      vt[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h4004, 1'b0, 16'h4010};
      vt[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h4008, 1'b1, 16'h4014};
      vt[9]  = '{1'b1, 16'h4123, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h4120};
      vt[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h4120, 1'b0, 16'h4120};
      vt[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h4120};
      vt[12] = '{1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h4120};
      vt[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFC};
      vt[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hFFFC, 1'b1, 16'h0000};
      vt[15] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0004};

      apply_reset();
      chk("reset_valid", 48'(instr_valid), 48'(0));
      chk("reset_en", 48'(mem_bus_enable), 48'(0));
      chk("reset_addr", 48'(mem_address), 48'(0));
      chk("reset_instr", 48'(instr), 48'(0));
      chk("reset_pc", 48'(instr_pc), 48'(0));

      // Table: backpressure fill, resume, flush with 3 buffered + 1 in flight, wrap
      for (int i = 0; i < 16; i++) begin
         flush = vt[i].fl; flush_pc = vt[i].fpc;
         bus_grant = vt[i].gr; instr_ready = vt[i].rd;
         step();
         chk($sformatf("vec%0d_valid", i), 48'(instr_valid), 48'(vt[i].ev));
         chk($sformatf("vec%0d_en", i), 48'(mem_bus_enable), 48'(vt[i].een));
         chk($sformatf("vec%0d_addr", i), 48'(mem_address), 48'(vt[i].eaddr));
         if (vt[i].ev) chk($sformatf("vec%0d_pc", i), 48'(instr_pc), 48'(vt[i].epc));
      end

      // Streaming with grant and ready held: one word per cycle from 0x4000
      apply_reset();
      flush = 0; bus_grant = 1; instr_ready = 1;
      step();
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("stream%0d_pc", k), 48'(instr_pc), 48'(16'h4000 + 16'(4 * k)));
         chk($sformatf("stream%0d_word", k), 48'(instr), 48'(mem_word(16'h4000 + 16'(4 * k))));
      end

      // Grant toggling with ready held
      for (int k = 0; k < 8; k++) begin
         bus_grant = k[0] ? 1'b0 : 1'b1;
         step();
      end

      // Asynchronous reset with FIFO full
      bus_grant = 1; instr_ready = 0;
      repeat (6) step();
      chk("full_valid", 48'(instr_valid), 48'(1));
      #2;
      reset = 1'b0;
      #1;
      chk("areset_valid", 48'(instr_valid), 48'(0));
      chk("areset_en", 48'(mem_bus_enable), 48'(0));
      chk("areset_addr", 48'(mem_address), 48'(0));
      chk("areset_instr", 48'(instr), 48'(0));
      chk("areset_pc", 48'(instr_pc), 48'(0));
      apply_reset();
      bus_grant = 1; instr_ready = 1;
      step();
      chk("restart_addr", 48'(mem_address), 48'(16'h4000));
      step();
      chk("restart_pc", 48'(instr_pc), 48'(16'h4000));

      // Randomized traffic against the model
      for (int k = 0; k < 1500; k++) begin
         flush       = ($urandom_range(0, 15) == 0);
         flush_pc    = ($urandom_range(0, 7) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                                    : 16'($urandom);
         bus_grant   = ($urandom_range(0, 9) < 7);
         instr_ready = ($urandom_range(0, 9) < 5);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
